// File: rtl/ram_port_arbiter.sv
// Shares one single-port block RAM between N_REQ requesters: round-robin issue with bus lock.
// Build option RAM_ARB_FIXED_PRIO0_EN: requester 0 wins every cycle it requests.
`timescale 1ns/1ps
module ram_port_arbiter #(
    parameter int N_REQ    = 2,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    lock_err,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_din,
    input  logic [DATA_W-1:0]       ram_dout
);
    localparam int IDX_W = (N_REQ > 2) ? 2 : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
`ifdef RAM_ARB_FIXED_PRIO0_EN
    localparam bit PRIO0_EN = 1'b1;
`else
    localparam bit PRIO0_EN = 1'b0;
`endif

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [N_REQ-1:0] gnt_raw;
    logic [N_REQ-1:0] vld_p1;
    logic             rr_found;
    logic [IDX_W-1:0] rr_sel, rr_cand;
    logic             prio0;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (v == IDX_W'(N_REQ - 1)) return '0;
        return v + 1'b1;
    endfunction

    assign prio0 = PRIO0_EN && req[0];

    // Round-robin search from ptr; requester 0 is left to the priority path when enabled
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        rr_cand  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!rr_found && req[rr_cand] && !(PRIO0_EN && rr_cand == '0)) begin
                rr_found = 1'b1;
                rr_sel   = rr_cand;
            end
            rr_cand = wrap_inc(rr_cand);
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        gnt_raw      = '0;
        lock_err     = 1'b0;
        case (state)
            ARB: begin
                if (prio0) begin
                    gnt_raw[0] = 1'b1;
                    if (lock[0]) begin
                        owner_nxt    = '0;
                        lock_cnt_nxt = CNT_W'(1);
                        state_nxt    = LOCKED;
                    end
                end else if (rr_found) begin
                    gnt_raw[rr_sel] = 1'b1;
                    ptr_nxt         = wrap_inc(rr_sel);
                    if (lock[rr_sel]) begin
                        owner_nxt    = rr_sel;
                        lock_cnt_nxt = CNT_W'(1);
                        state_nxt    = LOCKED;
                    end
                end
            end
            LOCKED: begin
                lock_cnt_nxt = lock_cnt + 1'b1;
                if (lock_cnt == CNT_MAX) begin
                    // Forced release: the owner loses this cycle, arbitration resumes next cycle
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                    lock_err     = 1'b1;
                    if (prio0) gnt_raw[0] = 1'b1;
                end else if (prio0) begin
                    gnt_raw[0] = 1'b1;
                    if (owner == '0 && !lock[0]) begin
                        state_nxt    = ARB;
                        lock_cnt_nxt = '0;
                    end
                end else if (req[owner]) begin
                    gnt_raw[owner] = 1'b1;
                    if (!lock[owner]) begin
                        state_nxt    = ARB;
                        lock_cnt_nxt = '0;
                    end
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Reset is asynchronous, so the combinational grant must also drop while it is held
    assign gnt = rst ? '0 : gnt_raw;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                ram_we   = we[i];
                ram_addr = addr[i*ADDR_W +: ADDR_W];
                ram_din  = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p1: read data returns from the RAM one cycle after issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= '0;
            owner    <= '0;
            lock_cnt <= '0;
            vld_p1   <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
            vld_p1   <= gnt & ~we;
        end
    end

    assign rvalid = vld_p1;
    assign rdata  = ram_dout;

endmodule
